// File: rtl/legv8_cache_pkg.sv
// Shared definitions for the LEGv8 cache controller slice.
// Holds the address-field geometry (57-bit tag, 5-bit set index, 2-bit byte
// offset), the 4-way organisation, the controller FSM state type and a
// helper that turns a way number into a one-hot write strobe vector.
package legv8_cache_pkg;

    localparam int ADDR_W   = 64;
    localparam int TAG_W    = 57;
    localparam int IDX_W    = 5;
    localparam int NUM_WAYS = 4;
    localparam int WAY_W    = 2;
    localparam int NUM_SETS = 1 << IDX_W;
    localparam int CNT_W    = 10;   // wide enough for timeouts up to 1023

    // Address field slices: tag=[63:7], index=[6:2], offset=[1:0].
    localparam int TAG_MSB  = 63;
    localparam int TAG_LSB  = 7;
    localparam int IDX_MSB  = 6;
    localparam int IDX_LSB  = 2;
    localparam int LINE_LSB = 2;    // bits below this are the ignored byte offset

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        FILL,
        RESP
    } state_e;

    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
        return NUM_WAYS'(1) << way;
    endfunction

endpackage

// File: rtl/legv8_victim_ptr.sv
// Per-set round-robin victim pointer table.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears every entry)
//   rd_idx    - set index being read / advanced
//   inc       - advance the pointer of rd_idx by one (3 wraps to 0)
//   rd_ptr    - current victim way for rd_idx (combinational read)
module legv8_victim_ptr
    import legv8_cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             inc,
    output logic [WAY_W-1:0] rd_ptr
);

    logic [WAY_W-1:0] ptr_q [NUM_SETS];

    // NOTE: this table is reset entry by entry, so it must stay in flops;
    // a RAM macro could not clear all 32 pointers in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                ptr_q[i] <= '0;
            end
        end else if (inc) begin
            // Two-bit add wraps 3 -> 0 on its own.
            ptr_q[rd_idx] <= ptr_q[rd_idx] + WAY_W'(1);
        end
    end

    assign rd_ptr = ptr_q[rd_idx];

endmodule

// File: rtl/legv8_cache_ctrl.sv
// Lookup / refill controller for a 4-way set-associative LEGv8 cache.
// Accepts one CPU request at a time, probes the external tag array, and on a
// miss requests a refill from backing memory, then writes the tag into the
// round-robin victim way of the set.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid, req_addr, req_ready - CPU request handshake
//   resp_valid, resp_hit, resp_err - one-cycle response strobe and status
//   Index, Tag, Write0..Write3     - tag array address, tag and way write strobes
//   hit_status                     - OR-of-ways hit returned by the tag array
//   mem_req, mem_addr, mem_ack     - refill request to backing memory
// MEM_TIMEOUT: last MISS counter value to wait for mem_ack before aborting.
module legv8_cache_ctrl
    import legv8_cache_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_err,
    output logic [IDX_W-1:0]  Index,
    output logic [TAG_W-1:0]  Tag,
    output logic              Write0,
    output logic              Write1,
    output logic              Write2,
    output logic              Write3,
    input  logic              hit_status,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:LINE_LSB] line_q, line_d;   // latched address minus byte offset
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     hit_q, hit_d;
    logic                     err_q, err_d;
    logic                     fill;
    logic [WAY_W-1:0]         victim;
    logic [NUM_WAYS-1:0]      write_vec;
    logic                     unused_offset;

    // The byte offset never influences the lookup.
    assign unused_offset = ^req_addr[LINE_LSB-1:0];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        fill       = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    line_d  = req_addr[ADDR_W-1:LINE_LSB];
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_status) begin
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_req = 1'b1;
                // An ack on the final counter value still completes the refill.
                if (mem_ack) begin
                    state_d = FILL;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FILL: begin
                fill    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    legv8_victim_ptr u_victim_ptr (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (line_q[IDX_MSB:IDX_LSB]),
        .inc    (fill),
        .rd_ptr (victim)
    );

    // Suppress the strobe in a reset cycle so the tag array is never written
    // by a refill that reset is abandoning.
    assign write_vec = (fill && !rst) ? way_onehot(victim) : '0;
    assign Write0    = write_vec[0];
    assign Write1    = write_vec[1];
    assign Write2    = write_vec[2];
    assign Write3    = write_vec[3];

    // Index/Tag/mem_addr come straight from the latched line address, so they
    // are stable from LOOKUP through RESP and hold their value in IDLE.
    assign Index    = line_q[IDX_MSB:IDX_LSB];
    assign Tag      = line_q[TAG_MSB:TAG_LSB];
    assign mem_addr = {line_q, {LINE_LSB{1'b0}}};

endmodule

// File: tb/tb_legv8_cache_ctrl.sv
module tb_legv8_cache_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic        req_ready, resp_valid, resp_hit, resp_err;
    logic [4:0]  Index;
    logic [56:0] Tag;
    logic        Write0, Write1, Write2, Write3;
    logic        hit_status = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;

    int total = 0;
    int bad   = 0;
    int victim [32];   // reference round-robin pointer per set

    // Status bundle: {req_ready, resp_valid, resp_hit, resp_err, mem_req, Write3..Write0}
    wire [8:0] obs = {req_ready, resp_valid, resp_hit, resp_err, mem_req,
                      Write3, Write2, Write1, Write0};

    localparam logic [8:0] S_IDLE = 9'b1_0000_0000;
    localparam logic [8:0] S_BUSY = 9'b0_0000_0000;
    localparam logic [8:0] S_MISS = 9'b0_0001_0000;

    legv8_cache_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_err(resp_err), .Index(Index), .Tag(Tag),
        .Write0(Write0), .Write1(Write1), .Write2(Write2), .Write3(Write3),
        .hit_status(hit_status), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        for (int i = 0; i < 32; i++) victim[i] = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete request. ack_at is the MISS cycle (0-based) in which
    // mem_ack is raised; values beyond TMO or negative mean it never is.
    task automatic access(input logic [63:0] addr, input bit hit, input int ack_at);
        logic [4:0]  idx;
        logic [56:0] tag;
        logic [3:0]  exp_wr;
        bit          exp_fill;
        int          exp_cycles;
        int          k;
        idx        = addr[6:2];
        tag        = addr[63:7];
        exp_fill   = !hit && ack_at >= 0 && ack_at <= TMO;
        exp_cycles = exp_fill ? ack_at + 1 : TMO + 1;

        total++;
        if (obs !== S_IDLE) begin
            bad++; $display("FAIL idle_ready: got %b want %b", obs, S_IDLE);
        end
        req_valid  = 1'b1;
        req_addr   = addr;
        hit_status = 1'b0;
        mem_ack    = 1'($urandom_range(0, 1));   // ignored outside MISS
        next_cycle();

        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        total++;
        if (obs !== S_BUSY || Index !== idx || Tag !== tag) begin
            bad++;
            $display("FAIL lookup: got st=%b idx=%0d tag=%h want st=%b idx=%0d tag=%h",
                     obs, Index, Tag, S_BUSY, idx, tag);
        end
        hit_status = hit;
        next_cycle();
        hit_status = 1'($urandom_range(0, 1));

        if (!hit) begin
            k = 0;
            while (mem_req === 1'b1 && k < 100) begin
                total++;
                if (obs !== S_MISS || mem_addr !== {addr[63:2], 2'b00}) begin
                    bad++;
                    $display("FAIL miss_hold: got st=%b addr=%h want st=%b addr=%h",
                             obs, mem_addr, S_MISS, {addr[63:2], 2'b00});
                end
                mem_ack = (k == ack_at);
                k++;
                next_cycle();
            end
            mem_ack = 1'($urandom_range(0, 1));
            total++;
            if (k !== exp_cycles) begin
                bad++; $display("FAIL miss_len: got %0d cycles want %0d", k, exp_cycles);
            end
            if (exp_fill) begin
                exp_wr      = 4'b0001 << victim[idx];
                victim[idx] = (victim[idx] + 1) % 4;
                total++;
                if (obs !== {5'b0, exp_wr}) begin
                    bad++; $display("FAIL fill_strobe: got %b want %b", obs, {5'b0, exp_wr});
                end
                next_cycle();
            end
        end

        total++;
        if (obs !== {2'b01, hit, !hit && !exp_fill, 5'b0} || Index !== idx || Tag !== tag) begin
            bad++;
            $display("FAIL resp: got st=%b idx=%0d want st=%b idx=%0d",
                     obs, Index, {2'b01, hit, !hit && !exp_fill, 5'b0}, idx);
        end
        next_cycle();
        mem_ack = 1'b0;
        total++;
        if (obs !== S_IDLE || Index !== idx || Tag !== tag) begin
            bad++;
            $display("FAIL back_idle: got st=%b idx=%0d tag=%h want st=%b idx=%0d tag=%h",
                     obs, Index, Tag, S_IDLE, idx, tag);
        end
    endtask

    // Drive a miss up to the first MISS cycle (checked on the way).
    task automatic start_miss(input logic [63:0] addr);
        total++;
        if (obs !== S_IDLE) begin
            bad++; $display("FAIL start_idle: got %b want %b", obs, S_IDLE);
        end
        req_valid  = 1'b1;
        req_addr   = addr;
        hit_status = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        total++;
        if (obs !== S_MISS) begin
            bad++; $display("FAIL start_miss: got %b want %b", obs, S_MISS);
        end
    endtask

    task automatic apply_reset_check(input string name);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_ack = 1'b0;
        clear_model();
        total++;
        if (obs !== S_IDLE || Index !== 5'd0 || Tag !== 57'd0 || mem_addr !== 64'd0) begin
            bad++;
            $display("FAIL %s: got st=%b idx=%0d tag=%h maddr=%h want st=%b and zeros",
                     name, obs, Index, Tag, mem_addr, S_IDLE);
        end
    endtask

    task automatic test_reset();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (obs !== S_IDLE || Index !== 5'd0 || Tag !== 57'd0 || mem_addr !== 64'd0) begin
            bad++;
            $display("FAIL reset_state: got st=%b idx=%0d tag=%h maddr=%h want st=%b and zeros",
                     obs, Index, Tag, mem_addr, S_IDLE);
        end
    endtask

    task automatic test_hit();
        access(64'h0000_0000_0000_0084, 1'b1, -1);
        access(64'hdead_beef_0000_1f7d, 1'b1, -1);
    endtask

    task automatic test_round_robin();
        logic [63:0] a;
        for (int i = 0; i < 5; i++) begin
            a = {57'(i + 10), 5'd3, 2'b01};
            access(a, 1'b0, 5);
        end
    endtask

    task automatic test_timeout();
        access({57'h1abc, 5'd9, 2'b00}, 1'b0, -1);
        access({57'h1abc, 5'd9, 2'b00}, 1'b0, TMO);  // ack on the last counter value
        access({57'h1abd, 5'd9, 2'b00}, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [63:0] a;
        for (int i = 0; i < 40; i++) begin
            a      = {$urandom, $urandom};
            a[6:2] = 5'($urandom_range(0, 3));
            access(a, 1'($urandom_range(0, 1)), $urandom_range(0, 11) - 1);
        end
    endtask

    task automatic test_reset_mid_miss();
        start_miss({57'h77, 5'd12, 2'b00});
        repeat (3) next_cycle();
        rst = 1'b1;
        apply_reset_check("reset_mid_miss");
        access({57'h99, 5'($urandom_range(0, 31)), 2'b00}, 1'b0, 2);
    endtask

    task automatic test_reset_mid_fill();
        access({57'h5, 5'd7, 2'b00}, 1'b0, 1);
        start_miss({57'h6, 5'd7, 2'b00});
        mem_ack = 1'b1;
        next_cycle();
        mem_ack = 1'b0;
        total++;
        if (obs !== {5'b0, 4'b0001 << victim[7]}) begin
            bad++; $display("FAIL fill_before_rst: got %b want %b", obs, {5'b0, 4'b0001 << victim[7]});
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs[3:0] !== 4'b0000) begin
            bad++; $display("FAIL write_in_rst: got %b want 0000", obs[3:0]);
        end
        apply_reset_check("reset_mid_fill");
        access({57'h8, 5'd7, 2'b00}, 1'b0, 3);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_round_robin();
        test_timeout();
        test_random();
        test_reset_mid_miss();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
